tile_filter_mux: RTL and testbench
==================================

Name: tile_filter_mux

Overview:
- Registered, parametrised successor of the fixed 2x2 quadrant filter mux.
- Splits the active frame into a GRID_X x GRID_Y tile grid and routes one of NUM_SRC filter outputs to each tile.
- Per-tile selections are written at any time into a shadow table and take effect only at a frame boundary. Optional auto-rotation of selections and a grid-line overlay are built in.
- Sits between the filter bank and the final output mux, in the sys_clk pixel domain.

Parameters:
- H_RES, 640, active width in pixels.
- V_RES, 480, active height in lines.
- GRID_X, 2, tile columns (1..4).
- GRID_Y, 2, tile rows (1..4).
- NUM_SRC, 4, number of 12-bit RGB444 sources (2..8).
- ROT_FRAMES, 60, frames between auto-rotation steps (>=1).
- LINE_TH, 3, grid-line thickness in pixels.
- LINE_RGB, 12'h0FF, grid-line colour {r,g,b}.

Ports:
- sys_clk, input, 1, pixel clock.
- reset, input, 1, asynchronous active-high reset.
- de_in, input, 1, display enable.
- hsync_in, input, 1, horizontal sync, passed through.
- vsync_in, input, 1, vertical sync; its rising edge marks the frame boundary.
- x_in, input, 10, pixel column.
- y_in, input, 10, pixel row.
- src_rgb_in, input, NUM_SRC*12, source s occupies bits [s*12+11 : s*12] as {r[3:0], g[3:0], b[3:0]}.
- cfg_we, input, 1, shadow-table write strobe.
- cfg_tile, input, 4, tile index ty*GRID_X+tx.
- cfg_src, input, 3, source index.
- rotate_en, input, 1, enable auto-rotation.
- grid_en, input, 1, enable grid-line overlay.
- rgb_out, output, 12, {r,g,b} output.
- de_out, output, 1, delayed de_in.
- hsync_out, output, 1, delayed hsync_in.
- vsync_out, output, 1, delayed vsync_in.
- cfg_pending, output, 1, shadow table differs from active table; set by an accepted write.

Behaviour:
- Single clock, sys_clk. reset is asynchronous and active-high; all flops clear on it.
- Reset values:
  - rgb_out=0, de_out=0, hsync_out=0, vsync_out=0, cfg_pending=0.
  - Frame counter=0, vsync edge register=0.
  - Shadow and active tables: entry t = t mod NUM_SRC.
- Reset mid-frame restores these values immediately; output stays 0 until the pipeline refills.
- Latency: exactly 2 sys_clk cycles from inputs to every output, for de, syncs and rgb alike.
- Stage 1 registers:
  - tx = number of internal boundaries bx_k = k*H_RES/GRID_X (k=1..GRID_X-1, integer division) with x_in >= bx_k; ty is the same using V_RES and GRID_Y.
  - line_hit = grid_en and x_in or y_in lies in [b_k, b_k+LINE_TH-1] for some internal boundary b_k.
  - de, syncs, src_rgb_in.
- Stage 2 registers:
  - de=0 -> rgb_out=0.
  - Otherwise line_hit -> LINE_RGB.
  - Otherwise the source selected by active[ty*GRID_X+tx].
- Thresholds are elaboration-time constants; no divider in hardware.
- Frame edge = vsync_in high while the registered previous vsync_in is low. It is a one-cycle internal pulse.
- Config write: when cfg_we=1, cfg_tile < GRID_X*GRID_Y and cfg_src < NUM_SRC, then shadow[cfg_tile] <= cfg_src and cfg_pending <= 1. Otherwise the write is ignored and nothing changes.
- Frame edge with cfg_pending=1:
  - active <= shadow, using the shadow contents before any same-cycle write.
  - Frame counter <= 0; no rotation on that frame.
  - cfg_pending <= 0, unless a write is accepted in the same cycle, in which case cfg_pending stays 1 and that write applies at the next edge.
- Frame edge with cfg_pending=0 and rotate_en=1:
  - Counter = ROT_FRAMES-1 -> every active[t] <= (active[t]+1) mod NUM_SRC; the shadow table gets the same update so the tables stay equal; counter <= 0.
  - Otherwise counter += 1.
- rotate_en=0: counter holds its value.
- The active table never changes except at a frame edge, so there is no tearing mid-frame.
- Selections with GRID_X*GRID_Y=1 behave as a registered single-source path.

Test Plan:
- After reset, 2x2 grid, sources set to constants 12'h100/12'h020/12'h003/12'h444, grid_en=0, de=1:
  - (10,10) -> 12'h100; (400,10) -> 12'h020; (10,300) -> 12'h003; (400,300) -> 12'h444.
  - Each appears 2 cycles after its input; de=0 -> 12'h000.
- grid_en=1:
  - x=320..322 on any row -> 12'h0FF.
  - x=319 and x=323 -> tile colour.
  - y=240..242 -> 12'h0FF.
- Write tile 0 = src 3 mid-frame:
  - cfg_pending=1; (10,10) still 12'h100 until the next vsync rising edge.
  - After the edge -> 12'h444; cfg_pending=0.
- Invalid writes (cfg_tile=4 or cfg_src=5):
  - Shadow unchanged, cfg_pending stays 0.
  - Write coincident with the frame edge: the old pending value applies, the new one applies next frame.
- rotate_en=1, ROT_FRAMES=2:
  - After 2 frame edges tile 0 -> 12'h020 and tile 3 -> 12'h100.
  - A pending write at a rotation edge overrides rotation and clears the counter.
- Assert reset mid-line:
  - All outputs 0 asynchronously; tables return to the identity map.
  - Output resumes 2 cycles after deassertion.

Source files
------------

// File: rtl/tile_filter_mux.sv
// Tile-grid source mux: routes one of NUM_SRC filter outputs to each tile of a
// GRID_X x GRID_Y grid. Selections change only at frame edges. Includes auto-rotation and a grid overlay.
module tile_filter_mux #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          GRID_X     = 2,
    parameter int          GRID_Y     = 2,
    parameter int          NUM_SRC    = 4,
    parameter int          ROT_FRAMES = 60,
    parameter int          LINE_TH    = 3,
    parameter logic [11:0] LINE_RGB   = 12'h0FF
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  de_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [9:0]            x_in,
    input  logic [9:0]            y_in,
    input  logic [NUM_SRC*12-1:0] src_rgb_in,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_tile,
    input  logic [2:0]            cfg_src,
    input  logic                  rotate_en,
    input  logic                  grid_en,
    output logic [11:0]           rgb_out,
    output logic                  de_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  cfg_pending
);

    localparam int NUM_TILES = GRID_X * GRID_Y;
    localparam int CNT_W     = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROT_FRAMES - 1);

    // Boundaries are constant expressions, so these unroll into fixed comparators.
    function automatic logic [1:0] tile_coord(input logic [9:0] p, input int res, input int grid);
        int n;
        n = 0;
        for (int k = 1; k < grid; k++) begin
            if (int'(p) >= (k * res) / grid) n++;
        end
        return 2'(n);
    endfunction

    function automatic logic on_line(input logic [9:0] p, input int res, input int grid);
        logic hit;
        int   b;
        hit = 1'b0;
        for (int k = 1; k < grid; k++) begin
            b = (k * res) / grid;
            if (int'(p) >= b && int'(p) <= b + LINE_TH - 1) hit = 1'b1;
        end
        return hit;
    endfunction

    logic                  s1_de, s1_hs, s1_vs, s1_hit;
    logic [1:0]            s1_tx, s1_ty;
    logic [NUM_SRC*12-1:0] s1_src;
    logic                  vs_prev;
    logic [CNT_W-1:0]      rot_cnt;
    logic [NUM_TILES*3-1:0] active_tab, shadow_tab, rot_tab;

    logic frame_edge, wr_ok, do_load, do_rot;

    always_comb begin
        frame_edge = vsync_in & ~vs_prev;
        wr_ok      = cfg_we && ({1'b0, cfg_tile} < 5'(NUM_TILES)) && ({1'b0, cfg_src} < 4'(NUM_SRC));
        do_load    = frame_edge & cfg_pending;
        do_rot     = frame_edge & ~cfg_pending & rotate_en & (rot_cnt == CNT_LAST);
    end

    always_comb begin
        logic [2:0] a;
        rot_tab = '0;
        for (int t = 0; t < NUM_TILES; t++) begin
            a = active_tab[t*3 +: 3];
            rot_tab[t*3 +: 3] = (a == 3'(NUM_SRC - 1)) ? 3'd0 : a + 3'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_hit  <= 1'b0;
            s1_tx   <= 2'd0;
            s1_ty   <= 2'd0;
            s1_src  <= '0;
            vs_prev <= 1'b0;
        end else begin
            s1_de   <= de_in;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
            s1_hit  <= grid_en & (on_line(x_in, H_RES, GRID_X) | on_line(y_in, V_RES, GRID_Y));
            s1_tx   <= tile_coord(x_in, H_RES, GRID_X);
            s1_ty   <= tile_coord(y_in, V_RES, GRID_Y);
            s1_src  <= src_rgb_in;
            vs_prev <= vsync_in;
        end
    end

    // Shadow rotates with the active table so both stay equal; a same-cycle write wins for its tile.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_TILES; t++) begin
                active_tab[t*3 +: 3] <= 3'(t % NUM_SRC);
                shadow_tab[t*3 +: 3] <= 3'(t % NUM_SRC);
            end
            cfg_pending <= 1'b0;
            rot_cnt     <= '0;
        end else begin
            if (do_load) begin
                active_tab <= shadow_tab;
            end else if (do_rot) begin
                active_tab <= rot_tab;
                shadow_tab <= rot_tab;
            end
            if (wr_ok) shadow_tab[int'(cfg_tile)*3 +: 3] <= cfg_src;

            if (wr_ok) cfg_pending <= 1'b1;
            else if (do_load) cfg_pending <= 1'b0;

            if (do_load || do_rot) rot_cnt <= '0;
            else if (frame_edge && rotate_en) rot_cnt <= rot_cnt + CNT_W'(1);
        end
    end

    logic [2:0]  sel;
    logic [11:0] pix;

    always_comb begin
        int idx;
        idx = int'(s1_ty) * GRID_X + int'(s1_tx);
        sel = active_tab[idx*3 +: 3];
        pix = s1_src[int'(sel)*12 +: 12];
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rgb_out   <= 12'h000;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            de_out    <= s1_de;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
            if (!s1_de)      rgb_out <= 12'h000;
            else if (s1_hit) rgb_out <= LINE_RGB;
            else             rgb_out <= pix;
        end
    end

endmodule

// File: tb/tb_tile_filter_mux.sv
// Scoreboard bench for tile_filter_mux: expected outputs are queued as stimulus
// is driven and compared two cycles later against rgb/de/hsync/vsync.
module tb_tile_filter_mux;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        de_in, hsync_in, vsync_in;
    logic [9:0]  x_in, y_in;
    logic [47:0] src_rgb_in;
    logic        cfg_we;
    logic [3:0]  cfg_tile;
    logic [2:0]  cfg_src;
    logic        rotate_en, grid_en;
    logic [11:0] rgb_out;
    logic        de_out, hsync_out, vsync_out, cfg_pending;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] src_val [4] = '{12'h100, 12'h020, 12'h003, 12'h444};
    int          exp_tab [4];
    logic [14:0] exp_q [$];
    string       tag_q [$];

    tile_filter_mux #(.ROT_FRAMES(2)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x_in(x_in), .y_in(y_in), .src_rgb_in(src_rgb_in),
        .cfg_we(cfg_we), .cfg_tile(cfg_tile), .cfg_src(cfg_src),
        .rotate_en(rotate_en), .grid_en(grid_en),
        .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .cfg_pending(cfg_pending)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // 2x2 grid on 640x480: boundaries at x=320, y=240, lines 3 px wide.
    function automatic logic [11:0] model(input int x, input int y);
        int t;
        if (grid_en && ((x >= 320 && x <= 322) || (y >= 240 && y <= 242))) return 12'h0FF;
        t = ((y >= 240) ? 2 : 0) + ((x >= 320) ? 1 : 0);
        return src_val[exp_tab[t]];
    endfunction

    task automatic applyStimulus(input logic de, input int x, input int y, input logic hs,
                                 input logic vs, input logic we, input int tile, input int src,
                                 input logic [11:0] exp_rgb, input string tag);
        @(negedge sys_clk);
        if (exp_q.size() >= 2)
            checkOutput(tag_q.pop_front(), {1'b0, rgb_out, de_out, hsync_out, vsync_out},
                        {1'b0, exp_q.pop_front()});
        de_in    = de;
        x_in     = 10'(x);
        y_in     = 10'(y);
        hsync_in = hs;
        vsync_in = vs;
        cfg_we   = we;
        cfg_tile = 4'(tile);
        cfg_src  = 3'(src);
        exp_q.push_back({exp_rgb, de, hs, vs});
        tag_q.push_back(tag);
    endtask

    task automatic pix(input int x, input int y, input string tag);
        applyStimulus(1'b1, x, y, 1'(x % 2), 1'b0, 1'b0, 0, 0, model(x, y), tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 12'h000, "idle");
    endtask

    task automatic cfgWrite(input int tile, input int src);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, tile, src, 12'h000, "cfg_wr");
    endtask

    task automatic framePulse(input logic we, input int tile, input int src);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, we, tile, src, 12'h000, "vs_rise");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 12'h000, "vs_high");
        idle(2);
    endtask

    task automatic checkPending(input string tag, input logic exp);
        checkOutput(tag, {15'd0, cfg_pending}, {15'd0, exp});
    endtask

    task automatic checkTiles(input string tag);
        pix(10, 10, {tag, "_t0"});
        pix(400, 10, {tag, "_t1"});
        pix(10, 300, {tag, "_t2"});
        pix(400, 300, {tag, "_t3"});
    endtask

    initial begin
        reset = 1'b1;
        de_in = 0; hsync_in = 0; vsync_in = 0; x_in = 0; y_in = 0;
        cfg_we = 0; cfg_tile = 0; cfg_src = 0; rotate_en = 0; grid_en = 0;
        src_rgb_in = {12'h444, 12'h003, 12'h020, 12'h100};
        for (int t = 0; t < 4; t++) exp_tab[t] = t;

        repeat (3) @(negedge sys_clk);
        checkOutput("reset_out", {1'b0, rgb_out, de_out, hsync_out, vsync_out}, 16'h0000);
        checkPending("reset_pending", 1'b0);
        reset = 1'b0;

        $display("[TB] tile routing");
        checkTiles("ident");
        applyStimulus(1'b0, 10, 10, 1'b1, 1'b0, 1'b0, 0, 0, 12'h000, "de_low");
        idle(2);

        $display("[TB] grid overlay");
        grid_en = 1'b1;
        for (int x = 319; x <= 323; x++) pix(x, 100, "grid_x");
        for (int y = 239; y <= 243; y++) pix(100, y, "grid_y");
        pix(0, 0, "grid_origin");
        idle(2);
        grid_en = 1'b0;
        idle(1);

        $display("[TB] shadow write mid-frame");
        applyStimulus(1'b1, 10, 10, 1'b0, 1'b0, 1'b1, 0, 3, 12'h100, "wr_mid");
        idle(1);
        checkPending("pending_set", 1'b1);
        pix(10, 10, "before_edge");
        framePulse(1'b0, 0, 0);
        checkPending("pending_clr", 1'b0);
        exp_tab[0] = 3;
        pix(10, 10, "after_edge");

        $display("[TB] invalid writes");
        cfgWrite(4, 1);
        cfgWrite(1, 5);
        idle(1);
        checkPending("invalid_pending", 1'b0);
        framePulse(1'b0, 0, 0);
        checkTiles("invalid");

        $display("[TB] write coincident with frame edge");
        cfgWrite(1, 2);
        idle(1);
        checkPending("coinc_pre", 1'b1);
        framePulse(1'b1, 2, 0);
        checkPending("coinc_still", 1'b1);
        exp_tab[1] = 2;
        checkTiles("coinc_a");
        framePulse(1'b0, 0, 0);
        checkPending("coinc_clr", 1'b0);
        exp_tab[2] = 0;
        checkTiles("coinc_b");

        $display("[TB] auto rotation");
        rotate_en = 1'b1;
        framePulse(1'b0, 0, 0);
        checkTiles("rot_f1");
        framePulse(1'b0, 0, 0);
        for (int t = 0; t < 4; t++) exp_tab[t] = (exp_tab[t] + 1) % 4;
        checkTiles("rot_f2");
        framePulse(1'b0, 0, 0);
        checkTiles("rot_f3");
        cfgWrite(0, 2);
        framePulse(1'b0, 0, 0);
        exp_tab[0] = 2;
        checkTiles("rot_override");
        framePulse(1'b0, 0, 0);
        checkTiles("rot_cnt_cleared");
        framePulse(1'b0, 0, 0);
        for (int t = 0; t < 4; t++) exp_tab[t] = (exp_tab[t] + 1) % 4;
        checkTiles("rot_again");
        idle(1);
        rotate_en = 1'b0;

        $display("[TB] reset mid-line");
        cfgWrite(3, 2);
        idle(1);
        checkPending("pre_reset_pending", 1'b1);
        checkTiles("pre_reset");
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_async", {1'b0, rgb_out, de_out, hsync_out, vsync_out}, 16'h0000);
        checkPending("reset_async_pending", 1'b0);
        de_in = 0; hsync_in = 0; vsync_in = 0; cfg_we = 0;
        exp_q.delete();
        tag_q.delete();
        for (int t = 0; t < 4; t++) exp_tab[t] = t;
        @(negedge sys_clk);
        reset = 1'b0;
        checkTiles("post_reset");
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
